// File: rtl/uart_host_link.sv
// Host link between the byte-level UART cores and the CPU: boot-time program
// loader (SYNC, size header, program words, ACK) and run-time stdin/stdout FIFOs.
module uart_host_link #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned SIZE_BYTES = 4,
   parameter int unsigned ADDR_STEP  = 4,
   parameter logic [7:0]  SYNC_BYTE  = 8'h99,
   parameter logic [7:0]  ACK_BYTE   = 8'hAA,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    boot_start,
   output logic                    boot_busy,
   output logic                    boot_done,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic [7:0]              tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic                    prog_we,
   output logic [ADDR_WIDTH-1:0]   prog_addr,
   output logic [8*WORD_BYTES-1:0] prog_wdata,
   output logic [7:0]              stdin_data,
   output logic                    stdin_valid,
   input  logic                    stdin_ready,
   output logic                    stdin_overflow,
   input  logic [7:0]              stdout_data,
   input  logic                    stdout_valid,
   output logic                    stdout_ready
);

   localparam int unsigned WORD_W = 8 * WORD_BYTES;
   localparam int unsigned SIZE_W = 8 * SIZE_BYTES;
   localparam int unsigned WIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int unsigned SIDX_W = (SIZE_BYTES > 1) ? $clog2(SIZE_BYTES) : 1;
   localparam int unsigned PW     = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W  = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SEND_SYNC, S_RX_SIZE, S_RX_PROG, S_SEND_ACK, S_RUN
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [SIDX_W-1:0]     r_size_idx;
   logic [SIZE_W-1:0]     r_size, r_remaining;
   logic [WIDX_W-1:0]     r_word_idx;
   logic [WORD_W-1:0]     r_word;
   logic [ADDR_WIDTH-1:0] r_next_addr, r_prog_addr;
   logic [WORD_W-1:0]     r_prog_wdata;
   logic                  r_prog_we, r_tx_start, r_overflow;
   logic [7:0]            r_tx_data;
   logic [7:0]            r_rxf_mem [FIFO_DEPTH];
   logic [7:0]            r_txf_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_rxf_wr, r_rxf_rd, r_txf_wr, r_txf_rd;

   logic              w_tx_idle, w_size_last, w_prog_byte, w_prog_last, w_word_last;
   logic [SIZE_W-1:0] w_size_cur;
   logic [WORD_W-1:0] w_word_cur;
   logic              w_rxf_empty, w_rxf_full, w_rxf_req, w_rxf_pop, w_rxf_push;
   logic              w_txf_empty, w_txf_full, w_txf_push, w_txf_fire, w_txf_pop;
   logic [7:0]        w_txf_head;

   assign w_tx_idle   = !tx_busy && !r_tx_start;
   assign w_size_cur  = r_size | (SIZE_W'(rx_data) << {r_size_idx, 3'b000});
   assign w_size_last = (r_state == S_RX_SIZE) && rx_valid &&
                        (r_size_idx == SIDX_W'(SIZE_BYTES - 1));
   assign w_prog_byte = (r_state == S_RX_PROG) && rx_valid;
   assign w_prog_last = (r_remaining == SIZE_W'(1));
   assign w_word_last = (r_word_idx == WIDX_W'(WORD_BYTES - 1));
   assign w_word_cur  = r_word | (WORD_W'(rx_data) << {r_word_idx, 3'b000});

   // Boot sequencer state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (boot_start) w_state_nxt = S_SEND_SYNC;
         S_SEND_SYNC: if (w_tx_idle)  w_state_nxt = S_RX_SIZE;
         S_RX_SIZE:   if (w_size_last)
                         w_state_nxt = (w_size_cur == '0) ? S_SEND_ACK : S_RX_PROG;
         S_RX_PROG:   if (w_prog_byte && w_prog_last) w_state_nxt = S_SEND_ACK;
         S_SEND_ACK:  if (w_tx_idle)  w_state_nxt = S_RUN;
         S_RUN:       w_state_nxt = S_RUN;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // Size header capture and program word packing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_size_idx <= '0; r_size <= '0; r_remaining <= '0;
         r_word_idx <= '0; r_word <= '0; r_next_addr <= '0;
         r_prog_we <= 1'b0; r_prog_addr <= '0; r_prog_wdata <= '0;
      end else begin
         r_prog_we <= 1'b0;
         if (r_state == S_IDLE && boot_start) begin
            r_size_idx <= '0; r_size <= '0;
            r_word_idx <= '0; r_word <= '0; r_next_addr <= '0;
         end
         if (r_state == S_RX_SIZE && rx_valid) begin
            r_size_idx  <= r_size_idx + SIDX_W'(1);
            r_size      <= w_size_cur;
            r_remaining <= w_size_cur;
         end
         if (w_prog_byte) begin
            r_remaining <= r_remaining - SIZE_W'(1);
            if (w_word_last || w_prog_last) begin
               r_prog_we    <= 1'b1;
               r_prog_wdata <= w_word_cur;
               r_prog_addr  <= r_next_addr;
               r_next_addr  <= r_next_addr + ADDR_WIDTH'(ADDR_STEP);
               r_word       <= '0;
               r_word_idx   <= '0;
            end else begin
               r_word     <= w_word_cur;
               r_word_idx <= r_word_idx + WIDX_W'(1);
            end
         end
      end
   end

   // RX FIFO: a push into a full FIFO survives only if the head pops that cycle
   assign w_rxf_empty = (r_rxf_wr == r_rxf_rd);
   assign w_rxf_full  = (r_rxf_wr[PW] != r_rxf_rd[PW]) &&
                        (r_rxf_wr[PW-1:0] == r_rxf_rd[PW-1:0]);
   assign w_rxf_req   = (r_state == S_RUN) && rx_valid;
   assign w_rxf_pop   = !w_rxf_empty && stdin_ready;
   assign w_rxf_push  = w_rxf_req && (!w_rxf_full || w_rxf_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rxf_wr <= '0; r_rxf_rd <= '0; r_overflow <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) r_rxf_mem[i] <= '0;
      end else begin
         if (w_rxf_push) begin
            r_rxf_mem[r_rxf_wr[PW-1:0]] <= rx_data;
            r_rxf_wr <= r_rxf_wr + PTR_W'(1);
         end
         if (w_rxf_pop) r_rxf_rd <= r_rxf_rd + PTR_W'(1);
         if (w_rxf_req && w_rxf_full && !w_rxf_pop) r_overflow <= 1'b1;
      end
   end

   // TX FIFO; an empty FIFO with an idle UART forwards the offered byte directly
   assign w_txf_empty = (r_txf_wr == r_txf_rd);
   assign w_txf_full  = (r_txf_wr[PW] != r_txf_rd[PW]) &&
                        (r_txf_wr[PW-1:0] == r_txf_rd[PW-1:0]);
   assign w_txf_push  = stdout_valid && stdout_ready;
   assign w_txf_fire  = (r_state == S_RUN) && w_tx_idle && (!w_txf_empty || w_txf_push);
   assign w_txf_pop   = w_txf_fire && !w_txf_empty;
   assign w_txf_head  = w_txf_empty ? stdout_data : r_txf_mem[r_txf_rd[PW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_txf_wr <= '0; r_txf_rd <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) r_txf_mem[i] <= '0;
      end else begin
         if (w_txf_push && !(w_txf_fire && w_txf_empty)) begin
            r_txf_mem[r_txf_wr[PW-1:0]] <= stdout_data;
            r_txf_wr <= r_txf_wr + PTR_W'(1);
         end
         if (w_txf_pop) r_txf_rd <= r_txf_rd + PTR_W'(1);
      end
   end

   // UART transmit request mux: SYNC, ACK, then stdout stream
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_start <= 1'b0; r_tx_data <= '0;
      end else begin
         r_tx_start <= 1'b0;
         if (r_state == S_SEND_SYNC && w_tx_idle) begin
            r_tx_start <= 1'b1; r_tx_data <= SYNC_BYTE;
         end else if (r_state == S_SEND_ACK && w_tx_idle) begin
            r_tx_start <= 1'b1; r_tx_data <= ACK_BYTE;
         end else if (w_txf_fire) begin
            r_tx_start <= 1'b1; r_tx_data <= w_txf_head;
         end
      end
   end

   assign boot_busy      = (r_state == S_SEND_SYNC) || (r_state == S_RX_SIZE) ||
                           (r_state == S_RX_PROG)   || (r_state == S_SEND_ACK);
   assign boot_done      = (r_state == S_RUN);
   assign tx_start       = r_tx_start;
   assign tx_data        = r_tx_data;
   assign prog_we        = r_prog_we;
   assign prog_addr      = r_prog_addr;
   assign prog_wdata     = r_prog_wdata;
   assign stdin_data     = r_rxf_mem[r_rxf_rd[PW-1:0]];
   assign stdin_valid    = !w_rxf_empty;
   assign stdin_overflow = r_overflow;
   assign stdout_ready   = (r_state == S_RUN) && !w_txf_full;

endmodule

// File: tb/tb_uart_host_link.sv
// Directed self-checking bench for uart_host_link: boot loads, RUN-mode FIFOs, reset.
module tb_uart_host_link;

   logic        clk, reset_n, boot_start, boot_busy, boot_done;
   logic [7:0]  rx_data, tx_data, stdin_data, stdout_data;
   logic        rx_valid, tx_start, tx_busy, prog_we;
   logic [14:0] prog_addr;
   logic [31:0] prog_wdata;
   logic        stdin_valid, stdin_ready, stdin_overflow, stdout_valid, stdout_ready;

   int          n_checks = 0;
   int          n_err    = 0;
   int          busy_len = 2;
   int          busy_cnt = 0;
   logic [7:0]  tx_q[$];
   logic [14:0] wa_q[$];
   logic [31:0] wd_q[$];

   uart_host_link dut (
      .clk(clk), .reset_n(reset_n), .boot_start(boot_start), .boot_busy(boot_busy),
      .boot_done(boot_done), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
      .tx_start(tx_start), .tx_busy(tx_busy), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .stdin_data(stdin_data), .stdin_valid(stdin_valid),
      .stdin_ready(stdin_ready), .stdin_overflow(stdin_overflow), .stdout_data(stdout_data),
      .stdout_valid(stdout_valid), .stdout_ready(stdout_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART TX model: busy for busy_len cycles starting the cycle after tx_start
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         tx_busy = (busy_cnt > 0);
         if (busy_cnt > 0) busy_cnt--;
         if (tx_start) busy_cnt = busy_len;
      end
   end

   always @(negedge clk) begin
      if (tx_start) tx_q.push_back(tx_data);
      if (prog_we) begin
         wa_q.push_back(prog_addr);
         wd_q.push_back(prog_wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input string tag, input logic [7:0] exp, input int max);
      for (int i = 0; i < max && tx_q.size() == 0; i++) tick();
      check({tag, "_seen"}, 64'(tx_q.size() != 0), 64'd1);
      if (tx_q.size() != 0) check(tag, 64'(tx_q.pop_front()), 64'(exp));
   endtask

   task automatic clear_q();
      tx_q.delete(); wa_q.delete(); wd_q.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0; boot_start = 1'b0; rx_valid = 1'b0; rx_data = '0;
      stdin_ready = 1'b0; stdout_valid = 1'b0; stdout_data = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      clear_q();
   endtask

   task automatic start_boot(input logic [31:0] size);
      boot_start = 1'b1; tick(); boot_start = 1'b0;
      wait_tx("sync", 8'h99, 20);
      for (int i = 0; i < 4; i++) send_byte(size[8*i +: 8]);
   endtask

   task automatic check_write(input string tag, input logic [14:0] a, input logic [31:0] d);
      check({tag, "_present"}, 64'(wa_q.size() != 0), 64'd1);
      if (wa_q.size() != 0) begin
         check({tag, "_addr"}, 64'(wa_q.pop_front()), 64'(a));
         check({tag, "_data"}, 64'(wd_q.pop_front()), 64'(d));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] pat5 [5];
      int         ready_drops;
      pat5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

      do_reset();
      check("rst_busy", 64'(boot_busy), 64'd0);
      check("rst_done", 64'(boot_done), 64'd0);
      check("rst_tx_start", 64'(tx_start), 64'd0);
      check("rst_prog_we", 64'(prog_we), 64'd0);
      check("rst_stdin_valid", 64'(stdin_valid), 64'd0);
      check("rst_stdout_ready", 64'(stdout_ready), 64'd0);
      check("rst_overflow", 64'(stdin_overflow), 64'd0);

      // 1: size 8, two full words
      start_boot(32'd8);
      check("t1_busy", 64'(boot_busy), 64'd1);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      wait_tx("t1_ack", 8'hAA, 40);
      check("t1_nwr", 64'(wa_q.size()), 64'd2);
      check_write("t1_w0", 15'd0, 32'h04030201);
      check_write("t1_w1", 15'd4, 32'h08070605);
      check("t1_done", 64'(boot_done), 64'd1);
      check("t1_busy_end", 64'(boot_busy), 64'd0);
      boot_start = 1'b1; tick(); boot_start = 1'b0;
      repeat (10) tick();
      check("t1_run_ignores_boot", 64'(tx_q.size()), 64'd0);

      // 2: size 5, partial last word zero-padded
      do_reset();
      start_boot(32'd5);
      foreach (pat5[i]) send_byte(pat5[i]);
      wait_tx("t2_ack", 8'hAA, 40);
      check("t2_nwr", 64'(wa_q.size()), 64'd2);
      check_write("t2_w0", 15'd0, 32'hDDCCBBAA);
      check_write("t2_w1", 15'd4, 32'h000000EE);

      // 3: size 0, ACK straight after header
      do_reset();
      start_boot(32'd0);
      wait_tx("t3_ack", 8'hAA, 40);
      check("t3_nwr", 64'(wa_q.size()), 64'd0);
      check("t3_done", 64'(boot_done), 64'd1);

      // 4: RX FIFO fill, push+pop on full, overflow, ordered drain
      send_byte(8'h10);
      check("t4_valid_lat", 64'(stdin_valid), 64'd1);
      check("t4_head", 64'(stdin_data), 64'h10);
      for (int i = 1; i < 16; i++) send_byte(8'(8'h10 + i));
      check("t4_full_no_ovf", 64'(stdin_overflow), 64'd0);
      rx_data = 8'h20; rx_valid = 1'b1; stdin_ready = 1'b1;
      tick();
      rx_valid = 1'b0; stdin_ready = 1'b0;
      check("t4_pushpop_no_ovf", 64'(stdin_overflow), 64'd0);
      send_byte(8'h21);
      check("t4_ovf", 64'(stdin_overflow), 64'd1);
      stdin_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t4_drain%0d", i), {55'd0, stdin_valid, stdin_data},
               {55'd0, 1'b1, 8'(8'h11 + i)});
         tick();
      end
      stdin_ready = 1'b0;
      check("t4_empty", 64'(stdin_valid), 64'd0);

      // 5: three stdout bytes back-to-back, slow UART
      busy_len = 10;
      repeat (20) tick();
      clear_q();
      for (int i = 0; i < 3; i++) begin
         stdout_data = 8'(8'h41 + i); stdout_valid = 1'b1;
         check($sformatf("t5_ready%0d", i), 64'(stdout_ready), 64'd1);
         tick();
         if (i == 0) check("t5_bypass_start", {55'd0, tx_start, tx_data}, {55'd0, 1'b1, 8'h41});
      end
      stdout_valid = 1'b0;
      ready_drops = 0;
      for (int i = 0; i < 60 && tx_q.size() < 3; i++) begin
         if (!stdout_ready) ready_drops++;
         tick();
      end
      repeat (15) tick();
      check("t5_ntx", 64'(tx_q.size()), 64'd3);
      for (int i = 0; i < 3 && tx_q.size() != 0; i++)
         check($sformatf("t5_tx%0d", i), 64'(tx_q.pop_front()), 64'(8'h41 + i));
      check("t5_ready_drops", 64'(ready_drops), 64'd0);
      busy_len = 2;

      // 6: async reset mid-RX_PROG, then a fresh boot restarts at address 0
      do_reset();
      start_boot(32'd8);
      for (int i = 1; i <= 5; i++) send_byte(8'(i));
      check("t6_pre_wdata", 64'(prog_wdata), 64'h04030201);
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_wdata", 64'(prog_wdata), 64'd0);
      check("t6_async_txdata", 64'(tx_data), 64'd0);
      check("t6_async_busy", 64'(boot_busy), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick();
      clear_q();
      start_boot(32'd4);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      wait_tx("t6_ack", 8'hAA, 40);
      check("t6_nwr", 64'(wa_q.size()), 64'd1);
      check_write("t6_w0", 15'd0, 32'h44332211);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
